ffjk_ers: RTL and testbench



---
 rtl/ffjk_ers.sv | 56 +++++
 tb/tb_ffjk_ers.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ffjk_ers.sv
// rtl/ffjk_ers.sv - bank of WIDTH independent JK flip-flops with clock enable and async reset
// Optional feature macro: FFJK_ERS_SET_EN (adds per-bit asynchronous active-high set input).
module ffjk_ers #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
`ifdef FFJK_ERS_SET_EN
  input  logic [WIDTH-1:0] set,
`endif
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] q
);

  // Characteristic equation q+ = J&~q | ~K&q covers hold/clear/set/toggle and
  // lets an X on J or K reach the affected bit instead of being decoded away.
  logic [WIDTH-1:0] q_next;

  // Next-state for every bit of the bank.
  always_comb begin
    q_next = (J & ~q) | (~K & q);
  end

  // One flop per bit so each bit can carry its own asynchronous set edge.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_q;

`ifdef FFJK_ERS_SET_EN
    // Reset beats set; set beats the clocked JK update.
    always_ff @(posedge clk or posedge reset or posedge set[i]) begin
      if (reset) begin
        bit_q <= RESET_VALUE[i];
      end else if (set[i]) begin
        bit_q <= 1'b1;
      end else begin
        bit_q <= enable ? q_next[i] : bit_q;
      end
    end
`else
    // Async reset, otherwise JK update gated by enable (ternary keeps X enable visible).
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        bit_q <= RESET_VALUE[i];
      end else begin
        bit_q <= enable ? q_next[i] : bit_q;
      end
    end
`endif

    assign q[i] = bit_q;
  end

endmodule

// File: tb/tb_ffjk_ers.sv
// tb/tb_ffjk_ers.sv - directed self-checking bench for ffjk_ers (WIDTH=1 and WIDTH=4)
`timescale 1ns/100ps
module tb_ffjk_ers;

  logic       clk = 1'b0;
  logic       reset1, en1;
  logic [0:0] j1, k1, q1;
  logic       reset4, en4;
  logic [3:0] j4, k4, q4, set4;
  logic [0:0] set1;

  int checks = 0;
  int errors = 0;

  always #2 clk = ~clk;

  ffjk_ers #(.WIDTH(1)) u1 (
    .clk(clk),
    .reset(reset1),
    .enable(en1),
`ifdef FFJK_ERS_SET_EN
    .set(set1),
`endif
    .J(j1),
    .K(k1),
    .q(q1)
  );

  ffjk_ers #(.WIDTH(4), .RESET_VALUE(4'b0101)) u4 (
    .clk(clk),
    .reset(reset4),
    .enable(en4),
`ifdef FFJK_ERS_SET_EN
    .set(set4),
`endif
    .J(j4),
    .K(k4),
    .q(q4)
  );

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
    end
  endtask

  initial begin
    reset1 = 1'b1; en1 = 1'b0; j1 = 1'b0; k1 = 1'b0; set1 = 1'b0;
    reset4 = 1'b1; en4 = 1'b0; j4 = 4'b0000; k4 = 4'b0000; set4 = 4'b0000;

    #1;  // t=1
    check("reset_q1", {3'b000, q1}, 4'b0000);
    check("reset_q4_value", q4, 4'b0101);
    #2;  // t=3, edge at 2 held by reset
    check("reset_hold_edge", {3'b000, q1}, 4'b0000);
    reset1 = 1'b0; en1 = 1'b1; j1 = 1'b0; k1 = 1'b0;
    #2;  // t=5
    j1 = 1'b0; k1 = 1'b1;
    #2;  // t=7, after edge 6 (clear)
    check("clear", {3'b000, q1}, 4'b0000);
    j1 = 1'b1; k1 = 1'b0;
    #4;  // t=11, after edge 10 (set)
    check("set", {3'b000, q1}, 4'b0001);
    j1 = 1'b1; k1 = 1'b1;
    #4;  // t=15, after edge 14
    check("toggle_1", {3'b000, q1}, 4'b0000);
    #4;  // t=19, after edge 18
    check("toggle_2", {3'b000, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b0;
    #4;  // t=23
    check("hold_22", {3'b000, q1}, 4'b0001);
    #4;  // t=27
    check("hold_26", {3'b000, q1}, 4'b0001);
    en1 = 1'b0; j1 = 1'b1; k1 = 1'b1;
    #4;  // t=31
    check("disabled_toggle", {3'b000, q1}, 4'b0001);
    j1 = 1'b0; k1 = 1'b1;
    #4;  // t=35
    check("disabled_clear", {3'b000, q1}, 4'b0001);
    en1 = 1'b1; j1 = 1'b1; k1 = 1'b1;
    #1;  // t=36, between edges, toggle pending
    reset1 = 1'b1;
    #1;  // t=37
    check("async_reset_mid", {3'b000, q1}, 4'b0000);
    #2;  // t=39, edge 38 during reset
    check("reset_ignores_edge", {3'b000, q1}, 4'b0000);
    reset1 = 1'b0;
    #4;  // t=43, edge 42 toggles 0->1
    check("toggle_after_release", {3'b000, q1}, 4'b0001);
    #12; // t=55, edges 46,50,54: 1 ^ (3 mod 2) = 0
    check("toggle_n3", {3'b000, q1}, 4'b0000);

    reset4 = 1'b0; en4 = 1'b1; j4 = 4'b1100; k4 = 4'b1010;
    #4;  // t=59, edge 58: toggle/set/clear/hold from 0101
    check("w4_mixed", q4, 4'b1101);
    en4 = 1'b0; j4 = 4'b1111; k4 = 4'b0000;
    #4;  // t=63
    check("w4_disabled", q4, 4'b1101);
    en4 = 1'b1; j4 = 4'b0000; k4 = 4'b1111;
    #4;  // t=67
    check("w4_clear_all", q4, 4'b0000);
    j4 = 4'b1111; k4 = 4'b1111;
    #4;  // t=71
    check("w4_toggle_all", q4, 4'b1111);

`ifdef FFJK_ERS_SET_EN
    j4 = 4'b0000; k4 = 4'b1111;
    #4;  // t=75
    check("w4_clear_again", q4, 4'b0000);
    en4 = 1'b0;
    #1;  // t=76
    set4 = 4'b0010;
    #1;  // t=77
    check("set_async", q4, 4'b0010);
    #2;  // t=79
    set4 = 4'b1111;
    #1;  // t=80
    check("set_all", q4, 4'b1111);
    reset4 = 1'b1;
    #1;  // t=81
    check("reset_over_set", q4, 4'b0101);
    #2;  // t=83, edge 82
    check("reset_over_set_edge", q4, 4'b0101);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
